// File: rtl/i2c_eeprom_pkg.sv
// i2c_eeprom_pkg: shared FSM states and device-type code for the I2C EEPROM
package i2c_eeprom_pkg;
  typedef enum logic [2:0] {IDLE, DEVSEL, ADDR_HI, ADDR_LO, WRITE, READ} state_e;
  localparam logic [3:0] DEVICE_TYPE = 4'b1010;
endpackage

// File: rtl/i2c_eeprom_ram.sv
// eeprom_ram: byte storage with a host-priority write port and two registered read ports
module eeprom_ram #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_data,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [7:0]        bus_data,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [7:0]        rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [7:0]        rdata_b
);
  logic [7:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (host_we) mem[host_addr] <= host_data;
    else if (bus_we) mem[bus_addr] <= bus_data;
    rdata_a <= mem[raddr_a];
    rdata_b <= mem[raddr_b];
  end
endmodule

// File: rtl/i2c_eeprom.sv
// i2c_eeprom: I2C slave EEPROM (24Cxx style) with page writes, sequential reads and a host save-state port
module i2c_eeprom
  import i2c_eeprom_pkg::*;
#(
  parameter int          ADDR_W   = 13,
  parameter int          PAGE_W   = 5,
  parameter logic [2:0]  CHIP_SEL = 3'b000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_ce,
  input  logic              scl,
  input  logic              sda_in,
  output logic              sda_out,
  input  logic              wp,
  input  logic              we,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [7:0]        write_data,
  input  logic [ADDR_W-1:0] read_address,
  output logic [7:0]        read_data
);
  state_e            state_q, state_d;
  logic              scl_q, scl_d, sda_q, sda_d, sda_o_q, sda_o_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        sh_q, sh_d, out_q, out_d, pend_data_q, pend_data_d, rd_b;
  logic [ADDR_W-1:0] addr_q, addr_d, pend_a_q, pend_a_d;
  logic              pend_v_q, pend_v_d;
  logic              scl_r, scl_f, start, stop, rx, bus_wr;

  assign scl_r   = clk_ce & scl & ~scl_q;
  assign scl_f   = clk_ce & ~scl & scl_q;
  assign start   = clk_ce & scl & scl_q & sda_q & ~sda_in;
  assign stop    = clk_ce & scl & scl_q & ~sda_q & sda_in;
  assign rx      = state_q inside {DEVSEL, ADDR_HI, ADDR_LO, WRITE};
  assign sda_out = sda_o_q;

  // cnt: 0..8 bits of the current byte, 9 = ACK slot in progress
  always_comb begin
    scl_d   = clk_ce ? scl : scl_q;
    sda_d   = clk_ce ? sda_in : sda_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    out_d   = out_q;
    addr_d  = addr_q;
    sda_o_d = sda_o_q;
    bus_wr  = 1'b0;
    if (start) begin
      state_d = DEVSEL;
      cnt_d   = 4'd0;
      sda_o_d = 1'b1;
    end else if (stop) begin
      state_d = IDLE;
      sda_o_d = 1'b1;
    end else if (rx) begin
      if (scl_r && cnt_q < 4'd8) begin
        sh_d  = {sh_q[6:0], sda_in};
        cnt_d = cnt_q + 4'd1;
      end else if (scl_f && cnt_q == 4'd9) begin
        sda_o_d = 1'b1;
        cnt_d   = 4'd0;
      end else if (scl_f && cnt_q == 4'd8) begin
        cnt_d   = 4'd9;
        sda_o_d = 1'b0;
        case (state_q)
          DEVSEL: begin
            state_d = sh_q[7:1] != {DEVICE_TYPE, CHIP_SEL} ? IDLE :
                      sh_q[0] ? READ : (ADDR_W > 8 ? ADDR_HI : ADDR_LO);
            sda_o_d = sh_q[7:1] != {DEVICE_TYPE, CHIP_SEL};
          end
          ADDR_HI: begin
            addr_d  = ADDR_W'((16'(addr_q) & 16'h00FF) | {sh_q, 8'h00});
            state_d = ADDR_LO;
          end
          ADDR_LO: begin
            addr_d  = ADDR_W'((16'(addr_q) & 16'hFF00) | {8'h00, sh_q});
            state_d = WRITE;
          end
          default: begin
            sda_o_d = wp;
            bus_wr  = ~wp;
            addr_d[PAGE_W-1:0] = addr_q[PAGE_W-1:0] + PAGE_W'(1);
          end
        endcase
      end
    end else if (state_q == READ) begin
      if (scl_r && cnt_q < 4'd8) cnt_d = cnt_q + 4'd1;
      else if (scl_r && cnt_q == 4'd8) begin
        state_d = sda_in ? IDLE : READ;
        addr_d  = sda_in ? addr_q : addr_q + ADDR_W'(1);
        cnt_d   = 4'd9;
      end else if (scl_f && cnt_q == 4'd9) begin
        out_d   = rd_b;
        sda_o_d = rd_b[7];
        cnt_d   = 4'd0;
      end else if (scl_f && cnt_q == 4'd8) sda_o_d = 1'b1;
      else if (scl_f && cnt_q != 4'd0) sda_o_d = out_q[3'd7 - cnt_q[2:0]];
    end
  end

  // bus writes always pass through the pending slot so a colliding host write lands first
  assign pend_v_d    = bus_wr | (pend_v_q & we);
  assign pend_a_d    = bus_wr ? addr_q : pend_a_q;
  assign pend_data_d = bus_wr ? sh_q : pend_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
      sda_o_q     <= 1'b1;
      cnt_q       <= 4'd0;
      sh_q        <= 8'd0;
      out_q       <= 8'd0;
      addr_q      <= '0;
      pend_v_q    <= 1'b0;
      pend_a_q    <= '0;
      pend_data_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      scl_q       <= scl_d;
      sda_q       <= sda_d;
      sda_o_q     <= sda_o_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      out_q       <= out_d;
      addr_q      <= addr_d;
      pend_v_q    <= pend_v_d;
      pend_a_q    <= pend_a_d;
      pend_data_q <= pend_data_d;
    end
  end

  eeprom_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk      (clk),
    .host_we  (we),
    .host_addr(write_address),
    .host_data(write_data),
    .bus_we   (pend_v_q),
    .bus_addr (pend_a_q),
    .bus_data (pend_data_q),
    .raddr_a  (read_address),
    .rdata_a  (read_data),
    .raddr_b  (addr_q),
    .rdata_b  (rd_b)
  );
endmodule

// File: tb/tb_i2c_eeprom.sv
// tb_i2c_eeprom: directed I2C transactions against i2c_eeprom with an open-drain bus model
module tb_i2c_eeprom;
  import i2c_eeprom_pkg::*;
  logic        clk = 1'b0, reset = 1'b1, clk_ce = 1'b1, wp = 1'b0, we = 1'b0;
  logic        scl, sda_in, sda_out;
  logic [12:0] write_address = '0, read_address = '0;
  logic [7:0]  write_data = '0, read_data;
  logic        scl_h = 1'b1, sda_h = 1'b1, mon = 1'b0, saw_low = 1'b0, a;
  logic [7:0]  d;
  int          checks = 0, failures = 0;

  assign scl    = scl_h;
  assign sda_in = sda_h & sda_out;

  always #5 clk = ~clk;
  always @(posedge clk) if (mon && !sda_out) saw_low = 1'b1;

  i2c_eeprom dut (
    .clk(clk), .reset(reset), .clk_ce(clk_ce), .scl(scl), .sda_in(sda_in), .sda_out(sda_out),
    .wp(wp), .we(we), .write_address(write_address), .write_data(write_data),
    .read_address(read_address), .read_data(read_data)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag, input logic [12:0] adr, input logic [7:0] exp);
    read_address = adr;
    tick(1);
    chk(tag, read_data, exp);
  endtask

  task automatic hwr(input logic [12:0] adr, input logic [7:0] dat);
    write_address = adr;
    write_data = dat;
    we = 1'b1;
    tick(1);
    we = 1'b0;
  endtask

  task automatic start_c;
    sda_h = 1'b1;
    tick(2);
    scl_h = 1'b1;
    tick(4);
    sda_h = 1'b0;
    tick(4);
    scl_h = 1'b0;
    tick(4);
  endtask

  task automatic stop_c;
    sda_h = 1'b0;
    tick(2);
    scl_h = 1'b1;
    tick(4);
    sda_h = 1'b1;
    tick(4);
  endtask

  task automatic bits8(input logic [7:0] b, input logic hw);
    for (int i = 7; i >= 0; i--) begin
      sda_h = b[i];
      tick(4);
      scl_h = 1'b1;
      tick(4);
      if (i == 0 && hw) we = 1'b1;
      scl_h = 1'b0;
      tick(2);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic hw, output logic ack);
    bits8(b, hw);
    sda_h = 1'b1;
    tick(4);
    we = 1'b0;
    scl_h = 1'b1;
    tick(2);
    ack = sda_in;
    tick(2);
    scl_h = 1'b0;
    tick(2);
  endtask

  task automatic recv(input logic hack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      tick(4);
      scl_h = 1'b1;
      tick(2);
      b[i] = sda_in;
      tick(2);
      scl_h = 1'b0;
    end
    tick(1);
    sda_h = hack;
    tick(4);
    scl_h = 1'b1;
    tick(4);
    scl_h = 1'b0;
    tick(2);
    sda_h = 1'b1;
    tick(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("rst_sda", 8'(sda_out), 8'h01);
    chk("rst_state", 8'(dut.state_q), 8'(IDLE));
    reset = 1'b0;
    tick(2);
    hwr(13'h0124, 8'h11);
    hwr(13'h0125, 8'h22);
    hwr(13'h0010, 8'h77);
    hwr(13'h0020, 8'h99);
    hwr(13'h0000, 8'h5C);
    chk_mem("host_load", 13'h0124, 8'h11);
    chk_mem("host_load0", 13'h0000, 8'h5C);
    // random write of 0x5A to 0x0123
    start_c;
    send(8'hA0, 1'b0, a); chk("wr_devsel_ack", 8'(a), 8'h00);
    send(8'h01, 1'b0, a); chk("wr_addr_hi_ack", 8'(a), 8'h00);
    send(8'h23, 1'b0, a); chk("wr_addr_lo_ack", 8'(a), 8'h00);
    send(8'h5A, 1'b0, a); chk("wr_data_ack", 8'(a), 8'h00);
    stop_c;
    chk_mem("wr_0123", 13'h0123, 8'h5A);
    // current-address sequential read continues at 0x0124
    start_c;
    send(8'hA1, 1'b0, a); chk("rd_devsel_ack", 8'(a), 8'h00);
    recv(1'b0, d); chk("rd_byte0", d, 8'h11);
    recv(1'b1, d); chk("rd_byte1", d, 8'h22);
    tick(2);
    chk("rd_idle", 8'(dut.state_q), 8'(IDLE));
    chk("rd_release", 8'(sda_out), 8'h01);
    stop_c;
    // page wrap inside a 32-byte page
    start_c;
    send(8'hA0, 1'b0, a);
    send(8'h01, 1'b0, a);
    send(8'h1F, 1'b0, a);
    send(8'hB1, 1'b0, a);
    send(8'hB2, 1'b0, a);
    send(8'hB3, 1'b0, a); chk("page_ack3", 8'(a), 8'h00);
    stop_c;
    chk_mem("page_011f", 13'h011F, 8'hB1);
    chk_mem("page_0100", 13'h0100, 8'hB2);
    chk_mem("page_0101", 13'h0101, 8'hB3);
    // write protect
    wp = 1'b1;
    start_c;
    send(8'hA0, 1'b0, a); chk("wp_devsel_ack", 8'(a), 8'h00);
    send(8'h00, 1'b0, a); chk("wp_addr_hi_ack", 8'(a), 8'h00);
    send(8'h10, 1'b0, a); chk("wp_addr_lo_ack", 8'(a), 8'h00);
    send(8'hFF, 1'b0, a); chk("wp_data_nack", 8'(a), 8'h01);
    stop_c;
    wp = 1'b0;
    chk_mem("wp_0010", 13'h0010, 8'h77);
    // wrong chip select stays silent
    saw_low = 1'b0;
    mon = 1'b1;
    start_c;
    send(8'hA2, 1'b0, a); chk("nodev_nack", 8'(a), 8'h01);
    send(8'h55, 1'b0, a); chk("nodev_nack2", 8'(a), 8'h01);
    stop_c;
    mon = 1'b0;
    chk("nodev_quiet", 8'(saw_low), 8'h00);
    // host write colliding with bus write to the same address: bus value ends up last
    write_address = 13'h0300;
    write_data = 8'hAA;
    start_c;
    send(8'hA0, 1'b0, a);
    send(8'h03, 1'b0, a);
    send(8'h00, 1'b0, a);
    send(8'h55, 1'b1, a); chk("coll_ack", 8'(a), 8'h00);
    stop_c;
    chk_mem("coll_same", 13'h0300, 8'h55);
    write_address = 13'h0400;
    write_data = 8'h3C;
    start_c;
    send(8'hA0, 1'b0, a);
    send(8'h04, 1'b0, a);
    send(8'h01, 1'b0, a);
    send(8'h66, 1'b1, a);
    stop_c;
    chk_mem("coll_host", 13'h0400, 8'h3C);
    chk_mem("coll_bus", 13'h0401, 8'h66);
    // reset while a bus write sits in the pending slot
    write_address = 13'h0030;
    write_data = 8'h44;
    start_c;
    send(8'hA0, 1'b0, a);
    send(8'h00, 1'b0, a);
    send(8'h20, 1'b0, a);
    bits8(8'h12, 1'b1);
    reset = 1'b1;
    tick(1);
    we = 1'b0;
    chk("rstmid_sda", 8'(sda_out), 8'h01);
    chk("rstmid_state", 8'(dut.state_q), 8'(IDLE));
    sda_h = 1'b1;
    scl_h = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4);
    chk_mem("rstmid_nopend", 13'h0020, 8'h99);
    chk_mem("rstmid_host", 13'h0030, 8'h44);
    // address pointer returns to 0 after reset
    start_c;
    send(8'hA1, 1'b0, a); chk("rst_rd_ack", 8'(a), 8'h00);
    recv(1'b1, d); chk("rst_addr0", d, 8'h5C);
    stop_c;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
